jogador_trilha: RTL

- Parametrised successor of the single-player light-cycle block.
- Moves a head on a cell grid at a programmable tick rate and turns on debounced-edge key presses.
- Keeps a shift-register trail of the last TRAIL_LEN cells and ends the game on collision with the arena wall, its own trail or the opponent's head.
- Produces registered per-pixel RGB for the VGA mixer; one instance per player in the top level.

---
 rtl/jogador_pkg.sv | 44 ++++
 rtl/trilha_buf.sv | 51 +++++
 rtl/jogador_trilha.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/jogador_pkg.sv
// Shared types and helpers for the light-cycle player block: directions,
// FSM states, default colours and the next-cell step function.
package jogador_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  localparam logic [23:0] HEAD_RGB_DEF  = 24'hFFFF00;
  localparam logic [23:0] TRAIL_RGB_DEF = 24'h808000;

  localparam int CELL_CALC_W = 16;

  typedef struct packed {
    logic [CELL_CALC_W-1:0] x;
    logic [CELL_CALC_W-1:0] y;
  } cell_t;

  // Wide arithmetic; callers keep the low COORD_W bits, which gives the
  // modular wrap (0-1 -> all ones) the collision check relies on.
  function automatic cell_t next_cell(input logic [CELL_CALC_W-1:0] x,
                                      input logic [CELL_CALC_W-1:0] y,
                                      input dir_t d);
    cell_t c;
    c.x = x;
    c.y = y;
    case (d)
      DIR_RIGHT: c.x = x + 16'd1;
      DIR_DOWN:  c.y = y + 16'd1;
      DIR_LEFT:  c.x = x - 16'd1;
      default:   c.y = y - 16'd1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/trilha_buf.sv
// Trail shift register: newest cell at entry 0, saturating valid count,
// and two parallel match probes (collision and render).
module trilha_buf #(
  parameter int COORD_W   = 7,
  parameter int TRAIL_LEN = 16
) (
  input  logic                           VGA_CLK,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic [COORD_W-1:0]             push_x,
  input  logic [COORD_W-1:0]             push_y,
  input  logic [COORD_W-1:0]             col_x,
  input  logic [COORD_W-1:0]             col_y,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  output logic                           col_hit,
  output logic                           pix_hit,
  output logic [$clog2(TRAIL_LEN+1)-1:0] count
);

  localparam int CNT_W = $clog2(TRAIL_LEN+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(TRAIL_LEN);

  logic [TRAIL_LEN-1:0][COORD_W-1:0] ent_x, ent_y;
  logic [TRAIL_LEN-1:0]              vld, col_m, pix_m;

  always_ff @(posedge VGA_CLK) begin
    if (reset || clear) begin
      count <= '0;
    end else if (push) begin
      ent_x[0] <= push_x;
      ent_y[0] <= push_y;
      for (int i = 1; i < TRAIL_LEN; i++) begin
        ent_x[i] <= ent_x[i-1];
        ent_y[i] <= ent_y[i-1];
      end
      if (count != FULL) count <= count + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < TRAIL_LEN; i++) begin : g_ent
    assign vld[i]   = CNT_W'(i) < count;
    assign col_m[i] = vld[i] && (ent_x[i] == col_x) && (ent_y[i] == col_y);
    assign pix_m[i] = vld[i] && (ent_x[i] == pix_x) && (ent_y[i] == pix_y);
  end

  assign col_hit = |col_m;
  assign pix_hit = |pix_m;

endmodule

// File: rtl/jogador_trilha.sv
// One light-cycle player: tick-paced head movement, key-driven turns,
// trail/wall/opponent collision and registered per-pixel colour.
module jogador_trilha
  import jogador_pkg::*;
#(
  parameter int          COORD_W     = 7,
  parameter int          CELL_LOG2   = 3,
  parameter int          START_X     = 27,
  parameter int          START_Y     = 30,
  parameter logic [1:0]  START_DIR   = 2'd0,
  parameter int          TRAIL_LEN   = 16,
  parameter int          TICK_PERIOD = 1000000,
  parameter int          ARENA_MIN_X = 2,
  parameter int          ARENA_MAX_X = 77,
  parameter int          ARENA_MIN_Y = 2,
  parameter int          ARENA_MAX_Y = 57,
  parameter logic [23:0] HEAD_RGB    = HEAD_RGB_DEF,
  parameter logic [23:0] TRAIL_RGB   = TRAIL_RGB_DEF
) (
  input  logic               VGA_CLK,
  input  logic               reset,
  input  logic               reiniciar,
  input  logic               KEY_ccw,
  input  logic               KEY_cw,
  input  logic [COORD_W-1:0] opp_x,
  input  logic [COORD_W-1:0] opp_y,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  output logic [7:0]         OUT_R,
  output logic [7:0]         OUT_G,
  output logic [7:0]         OUT_B,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic               fim_de_jogo
);

  localparam int TICK_W = $clog2(TICK_PERIOD);
  localparam int CNT_W  = $clog2(TRAIL_LEN+1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_PERIOD-1);
  localparam logic [COORD_W-1:0] SX   = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY   = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] MINX = COORD_W'(ARENA_MIN_X);
  localparam logic [COORD_W-1:0] MAXX = COORD_W'(ARENA_MAX_X);
  localparam logic [COORD_W-1:0] MINY = COORD_W'(ARENA_MIN_Y);
  localparam logic [COORD_W-1:0] MAXY = COORD_W'(ARENA_MAX_Y);

  state_t              state, state_nxt;
  dir_t                dir, pend_dir, edge_dir, turn_dir;
  logic                pend_vld;
  logic [TICK_W-1:0]   tick;
  logic                step, collide, push, col_hit, pix_hit;
  logic                ccw_q, ccw_q2, cw_q, cw_q2, ccw_fall, cw_fall, edge_one;
  cell_t               nc;
  logic [COORD_W-1:0]  cand_x, cand_y, pix_x, pix_y;
  logic [9:0]          px, py;
  logic                pix_ok, head_pix;
  logic [23:0]         pix_rgb;
  logic [CNT_W-1:0]    trail_cnt;
  logic                unused_hi;

  // Keys are registered once more before edge detection; idle level is 1.
  assign ccw_fall = ccw_q2 & ~ccw_q;
  assign cw_fall  = cw_q2 & ~cw_q;
  assign edge_one = ccw_fall ^ cw_fall;
  assign edge_dir = ccw_fall ? dir_t'(dir - 2'd1) : dir_t'(dir + 2'd1);
  // An edge landing in the step cycle itself still counts for this step.
  assign turn_dir = pend_vld ? pend_dir : (edge_one ? edge_dir : dir);

  assign step = (state == ST_RUN) && (tick == TICK_LAST);

  assign nc        = next_cell(CELL_CALC_W'(head_x), CELL_CALC_W'(head_y), turn_dir);
  assign cand_x    = nc.x[COORD_W-1:0];
  assign cand_y    = nc.y[COORD_W-1:0];
  assign unused_hi = ^{nc.x[CELL_CALC_W-1:COORD_W], nc.y[CELL_CALC_W-1:COORD_W]};

  assign collide = (cand_x < MINX) || (cand_x > MAXX) ||
                   (cand_y < MINY) || (cand_y > MAXY) ||
                   col_hit || ((cand_x == opp_x) && (cand_y == opp_y));
  assign push    = step && !collide && !reiniciar;

  trilha_buf #(.COORD_W(COORD_W), .TRAIL_LEN(TRAIL_LEN)) u_trail (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .clear   (reiniciar),
    .push    (push),
    .push_x  (head_x),
    .push_y  (head_y),
    .col_x   (cand_x),
    .col_y   (cand_y),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .col_hit (col_hit),
    .pix_hit (pix_hit),
    .count   (trail_cnt)
  );

  // Pixel cells beyond the coordinate range can never match anything.
  assign px       = next_x >> CELL_LOG2;
  assign py       = next_y >> CELL_LOG2;
  assign pix_ok   = ((px >> COORD_W) == '0) && ((py >> COORD_W) == '0);
  assign pix_x    = COORD_W'(px);
  assign pix_y    = COORD_W'(py);
  assign head_pix = pix_ok && (pix_x == head_x) && (pix_y == head_y);
  assign pix_rgb  = head_pix ? HEAD_RGB : ((pix_ok && pix_hit) ? TRAIL_RGB : 24'h0);

  always_ff @(posedge VGA_CLK) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (reiniciar)            state_nxt = ST_RUN;
    else if (step && collide) state_nxt = ST_DEAD;
  end

  assign fim_de_jogo = (state == ST_DEAD);

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      head_x   <= SX;
      head_y   <= SY;
      dir      <= dir_t'(START_DIR);
      tick     <= '0;
      pend_vld <= 1'b0;
      pend_dir <= DIR_RIGHT;
      ccw_q    <= 1'b1;
      ccw_q2   <= 1'b1;
      cw_q     <= 1'b1;
      cw_q2    <= 1'b1;
      {OUT_R, OUT_G, OUT_B} <= 24'h0;
    end else begin
      ccw_q  <= KEY_ccw;
      ccw_q2 <= ccw_q;
      cw_q   <= KEY_cw;
      cw_q2  <= cw_q;
      {OUT_R, OUT_G, OUT_B} <= pix_rgb;
      if (reiniciar) begin
        head_x   <= SX;
        head_y   <= SY;
        dir      <= dir_t'(START_DIR);
        tick     <= '0;
        pend_vld <= 1'b0;
      end else if (state == ST_RUN) begin
        tick <= step ? '0 : tick + TICK_W'(1);
        if (step) begin
          pend_vld <= 1'b0;
          if (!collide) begin
            head_x <= cand_x;
            head_y <= cand_y;
            dir    <= turn_dir;
          end
        end else if (edge_one && !pend_vld) begin
          pend_vld <= 1'b1;
          pend_dir <= edge_dir;
        end
      end
    end
  end

endmodule
